keypad_matrix_encoder: RTL and testbench



---
 rtl/keypad_matrix_encoder_if.sv | 25 ++
 rtl/keypad_matrix_encoder.sv | 191 +++++++++++++++++++
 tb/tb_keypad_matrix_encoder.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/keypad_matrix_encoder_if.sv
// Pin/user bundle for the 4x4 keypad encoder.
// The master side is the encoder itself.
interface keypad_matrix_encoder_if;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pressed;

    modport master (
        output col_n,
        output key_code,
        output key_valid,
        output key_pressed,
        input  row_n
    );

    modport slave (
        input  col_n,
        input  key_code,
        input  key_valid,
        input  key_pressed,
        output row_n
    );
endinterface

// File: rtl/keypad_matrix_encoder.sv
// 4x4 active-low keypad scanner with debounced single-key encoding.
// Emits a one-cycle valid strobe per accepted press.
module keypad_matrix_encoder #(
    parameter int SCAN_DIV       = 4,
    parameter int DEBOUNCE_SCANS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    keypad_matrix_encoder_if.master kp
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_C  = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CAND = 2'd1;
    localparam logic [1:0] HELD = 2'd2;

    logic [3:0]    meta_q, row_s_q;
    logic [SW-1:0] s_q;
    logic [1:0]    c_q;
    logic [3:0]    col_n_q;

    logic          acc_seen_q, acc_multi_q;
    logic [3:0]    acc_code_q;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cand_q, cand_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] rel_q, rel_d;
    logic [3:0]    code_q, code_d;
    logic          valid_q, valid_d;
    logic          pressed_q, pressed_d;

    logic          sample, scan_end;
    logic [3:0]    lows;
    logic          samp_none, samp_one;
    logic [1:0]    row_idx;
    logic          res_seen, res_multi;
    logic [3:0]    res_code;
    logic          res_none, res_single;
    logic          accept;

    assign sample   = (s_q == S_LAST);
    assign scan_end = sample && (c_q == 2'd3);

    // Row synchronizer, slot/column scan counters and column drive
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 4'hF;
            row_s_q <= 4'hF;
            s_q     <= '0;
            c_q     <= 2'd0;
            col_n_q <= 4'b1110;
        end else begin
            meta_q  <= kp.row_n;
            row_s_q <= meta_q;
            if (sample) begin
                s_q     <= '0;
                c_q     <= c_q + 2'd1;
                col_n_q <= ~(4'b0001 << (c_q + 2'd1));
            end else begin
                s_q <= s_q + SW'(1);
            end
        end
    end

    // Classify the current column sample and fold it into the scan result
    always_comb begin
        lows      = ~row_s_q;
        samp_none = (lows == 4'd0);
        samp_one  = !samp_none && ((lows & (lows - 4'd1)) == 4'd0);
        case (lows)
            4'b0010: row_idx = 2'd1;
            4'b0100: row_idx = 2'd2;
            4'b1000: row_idx = 2'd3;
            default: row_idx = 2'd0;
        endcase
        res_seen   = acc_seen_q || !samp_none;
        res_multi  = acc_multi_q
                   || (!samp_none && !samp_one)
                   || (samp_one && acc_seen_q);
        res_code   = (samp_one && !acc_seen_q) ? {row_idx, c_q}
                                               : acc_code_q;
        res_none   = !res_seen;
        res_single = res_seen && !res_multi;
    end

    // Scan accumulator, cleared after each scan end
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_seen_q  <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= 4'd0;
        end else if (scan_end) begin
            acc_seen_q  <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= 4'd0;
        end else if (sample) begin
            acc_seen_q  <= res_seen;
            acc_multi_q <= res_multi;
            acc_code_q  <= res_code;
        end
    end

    // Debounce FSM, advanced only at scan end
    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        rel_d     = rel_q;
        code_d    = code_q;
        valid_d   = 1'b0;
        pressed_d = pressed_q;
        accept    = 1'b0;
        if (scan_end) begin
            case (state_q)
                IDLE: begin
                    if (res_single) begin
                        cand_d = res_code;
                        cnt_d  = ONE_C;
                        if (DEB_C == ONE_C) accept  = 1'b1;
                        else                state_d = CAND;
                    end
                end
                CAND: begin
                    if (res_single && res_code == cand_q) begin
                        cnt_d = cnt_q + ONE_C;
                        if (cnt_q + ONE_C == DEB_C) accept = 1'b1;
                    end else if (res_single) begin
                        cand_d = res_code;
                        cnt_d  = ONE_C;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: begin
                    if (res_none) begin
                        if (rel_q + ONE_C == DEB_C) begin
                            rel_d     = '0;
                            pressed_d = 1'b0;
                            state_d   = IDLE;
                        end else begin
                            rel_d = rel_q + ONE_C;
                        end
                    end else begin
                        rel_d = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
            if (accept) begin
                code_d    = cand_d;
                valid_d   = 1'b1;
                pressed_d = 1'b1;
                rel_d     = '0;
                cnt_d     = '0;
                state_d   = HELD;
            end
        end
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cand_q    <= 4'd0;
            cnt_q     <= '0;
            rel_q     <= '0;
            code_q    <= 4'd0;
            valid_q   <= 1'b0;
            pressed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            rel_q     <= rel_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            pressed_q <= pressed_d;
        end
    end

    assign kp.col_n       = col_n_q;
    assign kp.key_code    = code_q;
    assign kp.key_valid   = valid_q;
    assign kp.key_pressed = pressed_q;
endmodule

// File: tb/tb_keypad_matrix_encoder.sv
// Directed bench for keypad_matrix_encoder with a keypad matrix model.
// Cycle counter cyc tracks scan phase from the last reset release.
module tb_keypad_matrix_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] keys = 16'd0;
    logic [3:0]  rn;
    int          cyc = 0;
    int          npulse = 0;
    int          pcyc = -1;
    int          total = 0;
    int          fails = 0;
    int          base;
    int          snap;

    keypad_matrix_encoder_if kp ();

    keypad_matrix_encoder #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .kp   (kp)
    );

    always #5 clk = ~clk;

    // Matrix model: pressed key (r,c) pulls row r low while column c driven
    always_comb begin
        rn = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !kp.col_n[c]) rn[r] = 1'b0;
    end
    assign kp.row_n = rn;

    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(posedge clk) begin
        if (kp.key_valid) begin
            npulse <= npulse + 1;
            pcyc   <= cyc;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic align(output int b);
        b = ((cyc / 16) + 1) * 16;
        wait_cyc(b);
    endtask

    initial begin
        logic [3:0] e;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset and scan sequence
        for (int i = 0; i < 17; i++) begin
            e = ~(4'b0001 << ((i / 4) % 4));
            check("col_scan", kp.col_n, e);
            @(negedge clk);
        end
        check("rst_valid", kp.key_valid, 0);
        check("rst_pressed", kp.key_pressed, 0);
        check("rst_code", kp.key_code, 0);

        // Clean press of key (2,1)
        align(base);
        snap = npulse;
        keys = 16'd1 << 9;
        wait_cyc(base + 47);
        check("cp_pre_valid", kp.key_valid, 0);
        check("cp_pre_pressed", kp.key_pressed, 0);
        wait_cyc(base + 48);
        check("cp_valid", kp.key_valid, 1);
        check("cp_code", kp.key_code, 9);
        check("cp_pressed", kp.key_pressed, 1);
        wait_cyc(base + 160);
        keys = 16'd0;
        wait_cyc(base + 207);
        check("cp_hold_pressed", kp.key_pressed, 1);
        wait_cyc(base + 208);
        check("cp_rel_pressed", kp.key_pressed, 0);
        wait_cyc(base + 240);
        check("cp_npulse", npulse - snap, 1);
        check("cp_pcyc", pcyc, base + 48);

        // Bounce on key (0,3)
        align(base);
        snap = npulse;
        for (int i = 0; i < 6; i++) begin
            keys = (i % 2 == 0) ? 16'd8 : 16'd0;
            wait_cyc(base + 5 * (i + 1));
        end
        keys = 16'd8;
        wait_cyc(base + 79);
        check("bn_pre_valid", kp.key_valid, 0);
        wait_cyc(base + 80);
        check("bn_valid", kp.key_valid, 1);
        check("bn_code", kp.key_code, 3);
        wait_cyc(base + 81);
        check("bn_post_valid", kp.key_valid, 0);
        wait_cyc(base + 96);
        keys = 16'd0;
        wait_cyc(base + 160);
        check("bn_npulse", npulse - snap, 1);
        check("bn_released", kp.key_pressed, 0);

        // Two keys at once never accepted
        align(base);
        snap = npulse;
        keys = 16'h8001;
        wait_cyc(base + 96);
        check("mk_npulse", npulse - snap, 0);
        check("mk_code", kp.key_code, 3);
        check("mk_pressed", kp.key_pressed, 0);
        keys = 16'd0;
        wait_cyc(base + 160);

        // Candidate change then a one-scan glitch while held
        align(base);
        snap = npulse;
        keys = 16'd1 << 5;
        wait_cyc(base + 32);
        keys = 16'd1 << 6;
        wait_cyc(base + 80);
        check("cc_valid", kp.key_valid, 1);
        check("cc_code", kp.key_code, 6);
        wait_cyc(base + 112);
        keys = 16'd0;
        wait_cyc(base + 128);
        check("gl_pressed_a", kp.key_pressed, 1);
        keys = 16'd1 << 6;
        wait_cyc(base + 160);
        check("gl_pressed_b", kp.key_pressed, 1);
        check("gl_npulse", npulse - snap, 1);
        wait_cyc(base + 176);
        keys = 16'd0;
        wait_cyc(base + 223);
        check("gl_hold", kp.key_pressed, 1);
        wait_cyc(base + 224);
        check("gl_rel", kp.key_pressed, 0);
        check("gl_code_kept", kp.key_code, 6);

        // Reset while held, then re-acceptance
        align(base);
        keys = 16'd1 << 9;
        wait_cyc(base + 48);
        check("rh_valid", kp.key_valid, 1);
        wait_cyc(base + 60);
        check("rh_pressed_pre", kp.key_pressed, 1);
        reset = 1'b1;
        @(negedge clk);
        check("rh_pressed_rst", kp.key_pressed, 0);
        check("rh_col_rst", kp.col_n, 4'b1110);
        check("rh_code_rst", kp.key_code, 0);
        reset = 1'b0;
        snap = npulse;
        wait_cyc(47);
        check("rh_pre_valid", kp.key_valid, 0);
        wait_cyc(48);
        check("rh_re_valid", kp.key_valid, 1);
        check("rh_re_code", kp.key_code, 9);
        wait_cyc(96);
        check("rh_npulse", npulse - snap, 1);
        keys = 16'd0;
        wait_cyc(160);
        check("rh_released", kp.key_pressed, 0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
